present_ctr_stream_ctrl: RTL and testbench

//  Sequencer for one present_ctr core. Turns it into a streaming CTR engine with valid/ready on both sides.

---
 rtl/present_ctr_stream_ctrl_if.sv | 27 ++
 rtl/present_ctr_stream_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_present_ctr_stream_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_ctr_stream_ctrl_if.sv
// Stream interface for present_ctr_stream_ctrl: configuration channel,
// input block stream (s_*) and output block stream (m_*).
// master = host/DMA side, slave = the sequencer.
interface present_ctr_stream_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [79:0] cfg_key;
    logic [63:0] cfg_iv;

    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;

    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;

    modport master (
        output cfg_valid, cfg_key, cfg_iv, s_valid, s_data, m_ready,
        input  cfg_ready, s_ready, m_valid, m_data
    );

    modport slave (
        input  cfg_valid, cfg_key, cfg_iv, s_valid, s_data, m_ready,
        output cfg_ready, s_ready, m_valid, m_data
    );
endinterface

// File: rtl/present_ctr_stream_ctrl.sv
// present_ctr_stream_ctrl: sequencer that turns one present_ctr core into a
// streaming CTR engine. Holds key/IV, owns the block counter, restarts the
// core once per block and buffers the processed block until taken.
// Optional watchdog: define PRESENT_CTR_TIMEOUT_EN to abort a block whose
// core never signals completion within TIMEOUT_CYCLES WAIT cycles.
module present_ctr_stream_ctrl #(
    parameter int CNT_W          = 64,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    present_ctr_stream_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     blk_cnt,
    output logic                 busy,
    output logic                 err,
    output logic                 core_rst,
    output logic [79:0]          core_key,
    output logic [63:0]          core_iv,
    output logic [63:0]          core_block_number,
    output logic [63:0]          core_block_i,
    input  logic [63:0]          core_block_o,
    input  logic                 core_end
);

    // Elaboration-time sanity check of the configuration.
    generate
        if (CNT_W < 1 || CNT_W > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("present_ctr_stream_ctrl: CNT_W must be 1..64, TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_UNCFG,
        ST_READY,
        ST_START,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t             state_reg, state_next;
    logic [79:0]        key_reg;
    logic [63:0]        iv_reg;
    logic [CNT_W-1:0]   blk_cnt_reg;
    logic [63:0]        data_reg;
    logic [63:0]        out_reg;

    logic               cfg_load;
    logic               blk_take;
    logic               blk_done;

`ifdef PRESENT_CTR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]    wd_cnt_reg;
    logic               err_reg;
    logic               wd_abort;
    logic               wd_hit;

    assign wd_hit = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_UNCFG;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle datapath enables.
    always_comb begin
        state_next = state_reg;
        cfg_load   = 1'b0;
        blk_take   = 1'b0;
        blk_done   = 1'b0;
`ifdef PRESENT_CTR_TIMEOUT_EN
        wd_abort   = 1'b0;
`endif
        case (state_reg)
            ST_UNCFG: begin
                if (bus.cfg_valid) begin
                    cfg_load   = 1'b1;
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                // A config load takes priority over a block offered in the same cycle.
                if (bus.cfg_valid) begin
                    cfg_load = 1'b1;
                end else if (bus.s_valid) begin
                    blk_take   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_end) begin
                    blk_done   = 1'b1;
                    state_next = ST_OUT;
                end
`ifdef PRESENT_CTR_TIMEOUT_EN
                else if (wd_hit) begin
                    wd_abort   = 1'b1;
                    state_next = ST_READY;
                end
`endif
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    state_next = ST_READY;
                end
            end
            default: begin
                state_next = ST_UNCFG;
            end
        endcase
    end

    // Config, input block, output block and block counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg     <= '0;
            iv_reg      <= '0;
            blk_cnt_reg <= '0;
            data_reg    <= '0;
            out_reg     <= '0;
        end else begin
            if (cfg_load) begin
                key_reg     <= bus.cfg_key;
                iv_reg      <= bus.cfg_iv;
                blk_cnt_reg <= '0;
            end
            if (blk_take) begin
                data_reg <= bus.s_data;
            end
            // Counter only advances when leaving WAIT, so the core sees a stable number.
            if (blk_done) begin
                out_reg     <= core_block_o;
                blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef PRESENT_CTR_TIMEOUT_EN
    // Watchdog counts WAIT cycles; sticky error cleared only by reset or config load.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end else begin
                wd_cnt_reg <= '0;
            end
            if (cfg_load) begin
                err_reg <= 1'b0;
            end else if (wd_abort) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign busy          = (state_reg == ST_START) || (state_reg == ST_WAIT) || (state_reg == ST_OUT);
    assign bus.cfg_ready = (state_reg == ST_UNCFG) || (state_reg == ST_READY);
    assign bus.s_ready   = (state_reg == ST_READY) && !bus.cfg_valid;
    assign bus.m_valid   = (state_reg == ST_OUT);
    assign bus.m_data    = out_reg;

    assign blk_cnt           = blk_cnt_reg;
    assign core_rst          = (state_reg != ST_WAIT);
    assign core_key          = key_reg;
    assign core_iv           = iv_reg;
    assign core_block_number = 64'(blk_cnt_reg);
    assign core_block_i      = data_reg;

endmodule

// File: tb/tb_present_ctr_stream_ctrl.sv
// Testbench for present_ctr_stream_ctrl. Includes a behavioural present_ctr
// core (PRESENT-80 keystream XOR data, programmable latency) and a
// scoreboard that predicts CTR outputs from key, IV and block index.
// Timeout scenario is compiled in when PRESENT_CTR_TIMEOUT_EN is defined.
module tb_present_ctr_stream_ctrl;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CNT_W-1:0]  blk_cnt;
    logic              busy;
    logic              err;
    logic              core_rst;
    logic [79:0]       core_key;
    logic [63:0]       core_iv;
    logic [63:0]       core_block_number;
    logic [63:0]       core_block_i;
    logic [63:0]       core_block_o;
    logic              core_end;

    present_ctr_stream_ctrl_if bus();

    present_ctr_stream_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(127)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .blk_cnt           (blk_cnt),
        .busy              (busy),
        .err               (err),
        .core_rst          (core_rst),
        .core_key          (core_key),
        .core_iv           (core_iv),
        .core_block_number (core_block_number),
        .core_block_i      (core_block_i),
        .core_block_o      (core_block_o),
        .core_end          (core_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [79:0] model_key;
    logic [63:0] model_iv;
    int          model_cnt;

    // Core model controls
    int   core_lat   = 0;
    logic core_stall = 1'b0;
    int   core_cyc   = 0;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] st, sb, pl;
        logic [79:0] k;
        st = pt;
        k  = key;
        for (int r = 1; r <= 31; r++) begin
            st = st ^ k[79:16];
            for (int i = 0; i < 16; i++) sb[i*4 +: 4] = sbox(st[i*4 +: 4]);
            for (int i = 0; i < 63; i++) pl[(i*16) % 63] = sb[i];
            pl[63] = sb[63];
            st = pl;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return st ^ k[79:16];
    endfunction

    // Behavioural present_ctr core: restarts while core_rst, finishes core_lat+1 cycles after release.
    always @(posedge clk) begin
        if (core_rst) begin
            core_cyc     <= 0;
            core_end     <= 1'b0;
            core_block_o <= '0;
        end else if (!core_end && !core_stall) begin
            if (core_cyc == core_lat) begin
                core_end     <= 1'b1;
                core_block_o <= core_block_i ^ present80(core_key, core_iv + core_block_number);
            end else begin
                core_cyc <= core_cyc + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a config (optionally colliding with an input block) and check acceptance.
    task automatic do_cfg(input logic [79:0] key, input logic [63:0] iv, input bit with_s);
        bus.cfg_valid = 1'b1;
        bus.cfg_key   = key;
        bus.cfg_iv    = iv;
        if (with_s) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 64'hDEAD_BEEF_0000_0001;
        end
        #1;
        check_eq("cfg_ready", 64'(bus.cfg_ready), 64'd1);
        if (with_s) check_eq("s_ready_collision", 64'(bus.s_ready), 64'd0);
        tick();
        bus.cfg_valid = 1'b0;
        model_key = key;
        model_iv  = iv;
        model_cnt = 0;
        check_eq("cfg_blk_cnt", 64'(blk_cnt), 64'd0);
        check_eq("cfg_no_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("cfg_not_busy", 64'(busy), 64'd0);
        $display("cfg key=%h iv=%h collide=%0d", key, iv, with_s);
    endtask

    // One full block: handshake in, wait for result, optional backpressure, handshake out.
    task automatic send_block(input logic [63:0] d, input int lat, input int hold, output logic [63:0] got);
        int          n;
        logic [63:0] exp;
        core_lat    = lat;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.m_ready = 1'b0;
        #1;
        check_eq("s_ready_idle", 64'(bus.s_ready), 64'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom();
        exp = d ^ present80(model_key, model_iv + 64'(model_cnt));
        n = 0;
        while (!bus.m_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("latency", 64'(n), 64'(lat + 3));
        for (int i = 0; i < hold; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_key   = {$urandom(), $urandom(), 16'(~$urandom())};
            #1;
            check_eq("hold_m_valid", 64'(bus.m_valid), 64'd1);
            check_eq("hold_m_data", bus.m_data, exp);
            check_eq("hold_s_ready", 64'(bus.s_ready), 64'd0);
            check_eq("hold_cfg_ready", 64'(bus.cfg_ready), 64'd0);
            tick();
        end
        bus.cfg_valid = 1'b0;
        bus.m_ready   = 1'b1;
        #1;
        got = bus.m_data;
        check_eq("m_valid", 64'(bus.m_valid), 64'd1);
        check_eq("m_data", bus.m_data, exp);
        check_eq("blk_cnt_inc", 64'(blk_cnt), 64'((model_cnt + 1) % (1 << CNT_W)));
        tick();
        bus.m_ready = 1'b0;
        check_eq("m_valid_drop", 64'(bus.m_valid), 64'd0);
        check_eq("back_ready", 64'(busy), 64'd0);
        $display("blk %0d in=%h out=%h lat=%0d hold=%0d", model_cnt, d, got, n, hold);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] got, got0;
        logic [63:0] d0;
        int          n;
        bus.cfg_valid = 1'b0;
        bus.cfg_key   = '0;
        bus.cfg_iv    = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        model_key = '0;
        model_iv  = '0;
        model_cnt = 0;

        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check_eq("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_core_rst", 64'(core_rst), 64'd1);
        check_eq("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        check_eq("rst_m_data", bus.m_data, 64'd0);

        // Known-answer blocks
        do_cfg(80'h0, 64'h0, 1'b0);
        send_block(64'h0, $urandom_range(0, 5), 0, got);
        check_eq("kat_zero", got, 64'h5579C1387B228445);
        do_cfg({80{1'b1}}, {64{1'b1}}, 1'b0);
        send_block(64'h0, $urandom_range(0, 5), 0, got);
        check_eq("kat_ones", got, 64'h3333DCD3213210D2);

        // Four-block stream with backpressure on the second
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b0);
        for (int b = 0; b < 4; b++) begin
            send_block({$urandom(), $urandom()}, $urandom_range(0, 6), (b == 1) ? 10 : 0, got);
        end
        check_eq("stream_blk_cnt", 64'(blk_cnt), 64'd4);

        // Config and block offered in the same cycle
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b1);
        send_block({$urandom(), $urandom()}, $urandom_range(0, 4), 0, got);

        // Counter wrap: block 16 reuses block 0's counter value
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b0);
        d0 = {$urandom(), $urandom()};
        send_block(d0, $urandom_range(0, 3), 0, got0);
        for (int b = 1; b < 16; b++) begin
            send_block({$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, 2), got);
        end
        check_eq("wrap_blk_cnt", 64'(blk_cnt), 64'd0);
        send_block(d0, $urandom_range(0, 3), 0, got);
        check_eq("wrap_same_out", got, got0);

`ifdef PRESENT_CTR_TIMEOUT_EN
        // Watchdog: core never finishes
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b0);
        send_block({$urandom(), $urandom()}, 1, 0, got);
        core_stall  = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = {$urandom(), $urandom()};
        tick();
        bus.s_valid = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            tick();
        end
        check_eq("wd_busy_cycles", 64'(n), 64'd128);
        check_eq("wd_err", 64'(err), 64'd1);
        check_eq("wd_ready", 64'(bus.s_ready), 64'd1);
        check_eq("wd_blk_cnt", 64'(blk_cnt), 64'd1);
        check_eq("wd_no_m_valid", 64'(bus.m_valid), 64'd0);
        $display("timeout abort after %0d busy cycles", n);
        core_stall = 1'b0;
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b0);
        check_eq("wd_err_cleared", 64'(err), 64'd0);
`else
        check_eq("err_tied", 64'(err), 64'd0);
`endif

        // Reset while the core is running
        core_stall  = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = {$urandom(), $urandom()};
        tick();
        bus.s_valid = 1'b0;
        repeat (3) tick();
        check_eq("midrst_busy", 64'(busy), 64'd1);
        check_eq("midrst_core_run", 64'(core_rst), 64'd0);
        rst = 1'b1;
        tick();
        check_eq("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        check_eq("midrst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check_eq("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        check_eq("midrst_busy_off", 64'(busy), 64'd0);
        check_eq("midrst_blk_cnt", 64'(blk_cnt), 64'd0);
        rst = 1'b0;
        core_stall = 1'b0;
        $display("reset during WAIT");
        tick();
        do_cfg({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 1'b0);
        send_block({$urandom(), $urandom()}, $urandom_range(0, 4), 0, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
